ramp_adc_controller: RTL
========================

// Module: ramp_adc_controller
// PURPOSE
//  Sequences one single-slope (ramp) ADC conversion around the LVDS comparator input.
//  Discharges the external ramp, gates the ramp clock, and counts hf_osc cycles until
//  the comparator trips. Returns the count through a valid/ready result port.
//  Sits between the comparator SB_IO (D_IN_0) / ramp-clock SB_IO and any sample consumer.
// PARAMETERS
//  CNT_W            12    width of conversion count / result
//  MAX_COUNT        4095  ramp timeout in RAMP cycles; must be < 2**CNT_W
//  DISCHARGE_CYCLES 64    cycles ramp_dis is held high before every ramp
//  SETTLE_CYCLES    16    cycles with discharge released, ramp stopped, before counting
//  AVG_LOG2         2     log2 of conversions per result (RAMP_ADC_AVG_EN only)
// PORTS
//  hf_osc        in   1      clock (6 MHz HFOSC domain)
//  rst           in   1      synchronous reset, active-high
//  start         in   1      conversion request, sampled only in IDLE
//  comp_in       in   1      raw comparator output, asynchronous
//  ramp_dis      out  1      1 = discharge ramp capacitor
//  ramp_run      out  1      1 = enable ramp reference clock
//  busy          out  1      1 whenever state != IDLE
//  result        out  CNT_W  conversion count, stable while result_valid
//  overflow      out  1      result hit MAX_COUNT without trip; qualified by result_valid
//  result_valid  out  1      result available
//  result_ready  in   1      consumer accepts result
// BEHAVIOUR
//  One clock, hf_osc; reset is synchronous and active-high on rst.
//  - Reset: state IDLE; ramp_dis=1, ramp_run=0, busy=0, result=0, overflow=0,
//    result_valid=0; synchronizer flops cleared. Reset mid-conversion aborts immediately.
//  - comp_in passes a 2-flop synchronizer -> comp_s; 2-cycle offset is NOT compensated.
//  - States / outputs (ramp_dis, ramp_run):
//    IDLE (1,0): start=1 -> DISCHARGE next cycle.
//    DISCHARGE (1,0): exactly DISCHARGE_CYCLES cycles -> SETTLE.
//    SETTLE (0,0): exactly SETTLE_CYCLES cycles -> RAMP; cnt cleared to 0.
//    RAMP (0,1): each cycle: comp_s=1 -> latch result=cnt, overflow=0, -> HOLD;
//      else cnt==MAX_COUNT -> result=MAX_COUNT, overflow=1, -> HOLD; else cnt++.
//    HOLD (1,0): result_valid=1; result_ready=1 -> IDLE (valid drops next cycle).
//  - comp_in rising in RAMP cycle n (0-based, first RAMP cycle = 0) gives result n+2.
//  - comp_s already 1 in first RAMP cycle -> result 0, overflow 0.
//  - start ignored outside IDLE; not queued. start+result_ready together in HOLD:
//    result consumed, start dropped; requester must re-assert in IDLE.
//  - result/overflow hold last value after handshake until next latch.
//  - cnt never wraps; saturates at MAX_COUNT by the timeout rule.
// CONFIGURATION
//  RAMP_ADC_AVG_EN defined: one start runs 2**AVG_LOG2 conversions back-to-back
//    (RAMP -> DISCHARGE loop, HOLD only after last); accumulator CNT_W+AVG_LOG2 bits,
//    cleared on start; result = acc >> AVG_LOG2 (truncate); overflow = OR of all runs.
//  Undefined: single conversion per start; AVG_LOG2 unused; no accumulator logic.
// STRUCTURE
//  Package ramp_adc_pkg: state enum (IDLE, DISCHARGE, SETTLE, RAMP, HOLD) and
//    encoding localparams; phase-length counter width function (clog2).
//  Sub-module sync_2ff: 2-flop synchronizer for comp_in (reusable for EU_BUTTON inputs).
//  One shared phase counter for DISCHARGE/SETTLE; separate cnt for RAMP.
// TESTING (DISCHARGE_CYCLES=4, SETTLE_CYCLES=2, MAX_COUNT=100, CNT_W=8)
//  1 rst high 3 cycles mid-RAMP -> IDLE, ramp_dis=1, ramp_run=0, result_valid=0, busy=0.
//  2 start pulse, comp_in rises at RAMP cycle 50 -> ramp_dis high 4 cycles, low/run=0 2
//    cycles, ramp_run 1; result=52, overflow=0, result_valid next cycle after trip.
//  3 comp_in held 0 -> result=100, overflow=1 after 101 RAMP cycles.
//  4 comp_in held 1 from before start -> result=0, overflow=0.
//  5 result_ready low 20 cycles in HOLD, start pulsed -> result/valid stable, start
//    ignored; ready=1 -> IDLE, no new conversion.
//  6 RAMP_ADC_AVG_EN, AVG_LOG2=2, trips at cycles 10,11,12,13 -> result=(12+13+14+15)>>2=13.

Source files
------------

// File: rtl/ramp_adc_pkg.sv
// Shared types and helpers for the single-slope ramp ADC controller.
package ramp_adc_pkg;

  localparam int unsigned StateW = 3;

  // State encodings, kept explicit so a logic analyser trace can be decoded by hand.
  localparam logic [StateW-1:0] EncIdle      = 3'd0;
  localparam logic [StateW-1:0] EncDischarge = 3'd1;
  localparam logic [StateW-1:0] EncSettle    = 3'd2;
  localparam logic [StateW-1:0] EncRamp      = 3'd3;
  localparam logic [StateW-1:0] EncHold      = 3'd4;

  typedef enum logic [StateW-1:0] {
    StIdle      = EncIdle,
    StDischarge = EncDischarge,
    StSettle    = EncSettle,
    StRamp      = EncRamp,
    StHold      = EncHold
  } state_e;

  // Bits needed for a counter running 0 .. n-1; never narrower than one bit.
  function automatic int unsigned ph_cnt_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops; reset clears both.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ramp_adc_controller.sv
// Single-slope ramp ADC sequencer: discharge, settle, ramp-and-count, hold result.
// Optional feature macro RAMP_ADC_AVG_EN: average 2**AVG_LOG2 conversions per start.
module ramp_adc_controller
  import ramp_adc_pkg::*;
#(
  parameter int unsigned CNT_W            = 12,
  parameter int unsigned MAX_COUNT        = 4095,
  parameter int unsigned DISCHARGE_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES    = 16,
  parameter int unsigned AVG_LOG2         = 2
) (
  input  logic             i_hf_osc,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_comp_in,
  output logic             o_ramp_dis,
  output logic             o_ramp_run,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_result,
  output logic             o_overflow,
  output logic             o_result_valid,
  input  logic             i_result_ready
);

  localparam int unsigned PhLen = (DISCHARGE_CYCLES > SETTLE_CYCLES) ? DISCHARGE_CYCLES
                                                                      : SETTLE_CYCLES;
  localparam int unsigned PhW   = ph_cnt_w(PhLen);

  localparam logic [PhW-1:0]   DisLast = PhW'(DISCHARGE_CYCLES - 1);
  localparam logic [PhW-1:0]   SetLast = PhW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_COUNT);

  // Elaboration-time parameter sanity.
  if (MAX_COUNT >= (64'd1 << CNT_W)) begin : g_bad_max_count
    $error("MAX_COUNT must be below 2**CNT_W");
  end
  if (AVG_LOG2 > 16) begin : g_bad_avg_log2
    $error("AVG_LOG2 out of range");
  end

  state_e           r_state, w_state_nxt;
  logic [PhW-1:0]   r_ph, w_ph_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_result, w_result_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             w_comp_s;

`ifdef RAMP_ADC_AVG_EN
  localparam int unsigned AccW  = CNT_W + AVG_LOG2;
  localparam int unsigned ConvW = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
  localparam logic [ConvW-1:0] ConvLast = ConvW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0]  r_acc, w_acc_nxt, w_acc_sum;
  logic [ConvW-1:0] r_conv, w_conv_nxt;
  logic             r_ovf_acc, w_ovf_acc_nxt;
`endif

  sync_2ff u_comp_sync (
    .i_clk (i_hf_osc),
    .i_rst (i_rst),
    .i_d   (i_comp_in),
    .o_q   (w_comp_s)
  );

  // State, phase counter, ramp counter and latched result.
  always_ff @(posedge i_hf_osc) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ph       <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
`ifdef RAMP_ADC_AVG_EN
      r_acc      <= '0;
      r_conv     <= '0;
      r_ovf_acc  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ph       <= w_ph_nxt;
      r_cnt      <= w_cnt_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
`ifdef RAMP_ADC_AVG_EN
      r_acc      <= w_acc_nxt;
      r_conv     <= w_conv_nxt;
      r_ovf_acc  <= w_ovf_acc_nxt;
`endif
    end
  end

  // Next-state sequencing and per-state outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_ph_nxt       = r_ph;
    w_cnt_nxt      = r_cnt;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;
    o_ramp_dis     = 1'b1;
    o_ramp_run     = 1'b0;
    o_busy         = (r_state != StIdle);
    o_result_valid = 1'b0;
`ifdef RAMP_ADC_AVG_EN
    w_acc_nxt      = r_acc;
    w_conv_nxt     = r_conv;
    w_ovf_acc_nxt  = r_ovf_acc;
    w_acc_sum      = r_acc + AccW'(r_cnt);
`endif

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt   = StDischarge;
          w_ph_nxt      = '0;
`ifdef RAMP_ADC_AVG_EN
          w_acc_nxt     = '0;
          w_conv_nxt    = '0;
          w_ovf_acc_nxt = 1'b0;
`endif
        end
      end
      StDischarge: begin
        if (r_ph == DisLast) begin
          w_state_nxt = StSettle;
          w_ph_nxt    = '0;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      StSettle: begin
        o_ramp_dis = 1'b0;
        if (r_ph == SetLast) begin
          w_state_nxt = StRamp;
          w_cnt_nxt   = '0;
        end else begin
          w_ph_nxt = r_ph + 1'b1;
        end
      end
      StRamp: begin
        o_ramp_dis = 1'b0;
        o_ramp_run = 1'b1;
        // On timeout r_cnt already equals MAX_COUNT, so r_cnt is the sample either way.
        if (w_comp_s || (r_cnt == CntMax)) begin
`ifdef RAMP_ADC_AVG_EN
          if (r_conv == ConvLast) begin
            w_state_nxt    = StHold;
            w_result_nxt   = CNT_W'(w_acc_sum >> AVG_LOG2);
            w_overflow_nxt = r_ovf_acc | ~w_comp_s;
          end else begin
            w_state_nxt   = StDischarge;
            w_ph_nxt      = '0;
            w_conv_nxt    = r_conv + 1'b1;
            w_acc_nxt     = w_acc_sum;
            w_ovf_acc_nxt = r_ovf_acc | ~w_comp_s;
          end
`else
          w_state_nxt    = StHold;
          w_result_nxt   = r_cnt;
          w_overflow_nxt = ~w_comp_s;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StHold: begin
        o_result_valid = 1'b1;
        if (i_result_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign o_result   = r_result;
  assign o_overflow = r_overflow;

endmodule
